// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM block-transfer datapath.
// Holds the sequencer state encoding, word/register constants and the addressing-mode pair.
package arm_pkg;

    localparam int WORD_BYTES = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic up;
        logic pre;
    } addr_mode_t;

    function automatic logic [4:0] popcount16(input logic [NUM_REGS-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lsb_enc16.sv
// Lowest-set-bit encoder over a 16-bit register mask.
// valid_o is low when the mask is empty; idx_o is then 0.
module lsb_enc16
    import arm_pkg::*;
(
    input  logic [NUM_REGS-1:0] vec_i,
    output logic [3:0]          idx_o,
    output logic                valid_o
);

    always_comb begin
        idx_o   = 4'd0;
        valid_o = |vec_i;
        // Scanning downward lets the lowest set bit win.
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks a register list lowest-first, one word per memory handshake.
// STM reads the register file and writes memory; LDM reads memory and writes the register file.
module ldm_stm_seq
    import arm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              up,
    input  logic              pre,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr,
    output logic              pc_loaded,
    output logic [3:0]        rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic [3:0]        rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_w_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    seq_state_e        state_q;
    logic              is_load_q;
    logic [15:0]       mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] final_addr_q;
    logic              pc_loaded_q;

    logic [3:0]        cur;
    logic              cur_vld;
    logic [15:0]       mask_d;
    addr_mode_t        mode;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr_d;
    logic [ADDR_W-1:0] final_addr_d;
    logic              xfer_ack;

    // The current register is always the lowest bit still pending in the mask.
    lsb_enc16 u_lsb_enc (
        .vec_i   (mask_q),
        .idx_o   (cur),
        .valid_o (cur_vld)
    );

    assign mask_d   = mask_q & ~(16'(1) << cur);
    assign xfer_ack = (state_q == XFER) && mem_ack && cur_vld;
    assign mode     = '{up: up, pre: pre};

    // Block bounds: the transfer always ascends from the lowest address of the block.
    always_comb begin
        span = ADDR_W'(popcount16(reg_list)) * ADDR_W'(WORD_BYTES);
        case ({mode.up, mode.pre})
            2'b10:   start_addr_d = base_addr;
            2'b11:   start_addr_d = base_addr + ADDR_W'(WORD_BYTES);
            2'b01:   start_addr_d = base_addr - span;
            default: start_addr_d = base_addr - span + ADDR_W'(WORD_BYTES);
        endcase
        final_addr_d = mode.up ? (base_addr + span) : (base_addr - span);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            mask_q       <= '0;
            addr_q       <= '0;
            final_addr_q <= '0;
            pc_loaded_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_load_q    <= is_load;
                        mask_q       <= reg_list;
                        addr_q       <= start_addr_d;
                        final_addr_q <= final_addr_d;
                        pc_loaded_q  <= is_load & reg_list[15];
                        state_q      <= (reg_list == 16'd0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (xfer_ack) begin
                        mask_q <= mask_d;
                        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                        if (mask_d == 16'd0) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign mem_req    = (state_q == XFER);
    assign mem_we     = mem_req & ~is_load_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_we ? rf_r_data : '0;
    assign rf_r_addr  = cur;
    // Register-file writes happen only in the ack cycle of a load.
    assign rf_w_en    = xfer_ack & is_load_q;
    assign rf_w_addr  = rf_w_en ? cur : 4'd0;
    assign rf_w_data  = rf_w_en ? mem_rdata : '0;
    assign final_addr = final_addr_q;
    assign pc_loaded  = pc_loaded_q;

endmodule
